// File: rtl/cv32e40p_ft_pkg.sv
`default_nettype none
// ============================================================================
// Module      : cv32e40p_ft_pkg
// Description : Shared types and constants for the fault-tolerant cv32e40p
//               error monitor (lane classification and request handshake).
// Contents    : lane_state_e  - per-triplet health classification
//               req_state_e   - recovery request handshake state
//               RUN_W         - width of the per-lane consecutive-run counter
// Revision    : 1.0 - initial release
// ============================================================================
package cv32e40p_ft_pkg;

  localparam int RUN_W = 8;

  typedef enum logic [1:0] {
    OK        = 2'd0,
    SUSPECT   = 2'd1,
    PERMANENT = 2'd2
  } lane_state_e;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    REQ  = 1'b1
  } req_state_e;

endpackage
`default_nettype wire

// File: rtl/cv32e40p_ft_err_monitor_if.sv
`default_nettype none
// ============================================================================
// Module      : cv32e40p_ft_err_monitor_if
// Description : Signal bundle between the TMR voters / recovery logic and the
//               error monitor.
// Ports       : valid_i, err_corrected_i, err_detected_i, clear_i, ack_i
//                 - driven by the environment (master)
//               lane_state_o, corr_cnt_o, fatal_o, req_o, req_lane_o,
//               req_fatal_o
//                 - driven by the monitor (slave)
// Revision    : 1.0 - initial release
// ============================================================================
interface cv32e40p_ft_err_monitor_if #(
  parameter int N_IN   = 1,
  parameter int CNT_W  = 16,
  parameter int LANE_W = 1
);

  logic                        valid_i;
  logic [N_IN-1:0]             err_corrected_i;
  logic [N_IN-1:0]             err_detected_i;
  logic                        clear_i;
  logic [N_IN-1:0][1:0]        lane_state_o;
  logic [N_IN-1:0][CNT_W-1:0]  corr_cnt_o;
  logic                        fatal_o;
  logic                        req_o;
  logic [LANE_W-1:0]           req_lane_o;
  logic                        req_fatal_o;
  logic                        ack_i;

  modport master (
    output valid_i, err_corrected_i, err_detected_i, clear_i, ack_i,
    input  lane_state_o, corr_cnt_o, fatal_o, req_o, req_lane_o, req_fatal_o
  );

  modport slave (
    input  valid_i, err_corrected_i, err_detected_i, clear_i, ack_i,
    output lane_state_o, corr_cnt_o, fatal_o, req_o, req_lane_o, req_fatal_o
  );

endinterface
`default_nettype wire

// File: rtl/cv32e40p_ft_lane_monitor.sv
`default_nettype none
// ============================================================================
// Module      : cv32e40p_ft_lane_monitor
// Description : Health tracker for one voter triplet. Classifies the voter
//               flags, runs the OK/SUSPECT/PERMANENT state machine with a
//               consecutive-corrected run counter, keeps an optional
//               saturating corrected-event counter and produces the lane's
//               pending / fatal flags for the request arbiter.
// Ports       : clk, rst      - clock, synchronous active-high reset
//               clear_i       - clear all lane state (beats everything else)
//               valid_i       - voter flags meaningful this cycle
//               corrected_i   - voter corrected flag for this lane
//               detected_i    - voter detected flag for this lane
//               ack_i         - the outstanding request for this lane is done
//               state_o       - lane classification
//               cnt_o         - corrected-event counter (0 if not built)
//               pending_o     - lane needs a recovery request
//               lane_fatal_o  - pending event includes an uncorrectable one
//               uncorr_o      - uncorrectable event this cycle
// Config      : FT_ERR_COUNTERS_EN - builds the corrected-event counter
// Revision    : 1.0 - initial release
// ============================================================================
module cv32e40p_ft_lane_monitor
  import cv32e40p_ft_pkg::*;
#(
  parameter int PERM_THRESH = 4,
  parameter int CNT_W       = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clear_i,
  input  logic              valid_i,
  input  logic              corrected_i,
  input  logic              detected_i,
  input  logic              ack_i,
  output lane_state_e       state_o,
  output logic [CNT_W-1:0]  cnt_o,
  output logic              pending_o,
  output logic              lane_fatal_o,
  output logic              uncorr_o
);

  localparam logic [RUN_W-1:0] c_perm_run = RUN_W'(PERM_THRESH);

  lane_state_e      state_q, state_d;
  logic [RUN_W-1:0] run_q, run_d;
  logic             pending_q, pending_d;
  logic             lfatal_q, lfatal_d;

  logic w_corr;
  logic w_uncorr;
  logic w_clean;
  logic w_enter_perm;

  // Corrected takes precedence: corrected without detected is still corrected.
  assign w_corr   = valid_i & corrected_i;
  assign w_uncorr = valid_i & detected_i & ~corrected_i;
  assign w_clean  = valid_i & ~detected_i & ~corrected_i;

  always_comb begin
    state_d      = state_q;
    run_d        = run_q;
    w_enter_perm = 1'b0;
    unique case (state_q)
      OK: begin
        if (w_corr) begin
          state_d = SUSPECT;
          run_d   = RUN_W'(1);
        end
      end
      SUSPECT: begin
        if (w_corr) begin
          run_d = run_q + RUN_W'(1);
          if (run_d == c_perm_run) begin
            state_d      = PERMANENT;
            w_enter_perm = 1'b1;
          end
        end else if (w_clean) begin
          state_d = OK;
          run_d   = '0;
        end
      end
      PERMANENT: begin
        state_d = PERMANENT;
      end
      default: begin
        state_d = OK;
        run_d   = '0;
      end
    endcase

    // Acknowledge drops the flags first so that an event in the same cycle
    // re-arms them and is not lost.
    pending_d = pending_q;
    lfatal_d  = lfatal_q;
    if (ack_i) begin
      pending_d = 1'b0;
      lfatal_d  = 1'b0;
    end
    if (w_enter_perm || w_uncorr) begin
      pending_d = 1'b1;
    end
    if (w_uncorr) begin
      lfatal_d = 1'b1;
    end

    if (clear_i) begin
      state_d   = OK;
      run_d     = '0;
      pending_d = 1'b0;
      lfatal_d  = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= OK;
      run_q     <= '0;
      pending_q <= 1'b0;
      lfatal_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      run_q     <= run_d;
      pending_q <= pending_d;
      lfatal_q  <= lfatal_d;
    end
  end

`ifdef FT_ERR_COUNTERS_EN
  logic [CNT_W-1:0] cnt_q, cnt_d;

  // Saturating: once all ones the counter stops, it never wraps.
  always_comb begin
    cnt_d = cnt_q;
    if (w_corr && (cnt_q != {CNT_W{1'b1}})) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
    if (clear_i) begin
      cnt_d = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt_o = cnt_q;
`else
  assign cnt_o = '0;
`endif

  assign state_o      = state_q;
  assign pending_o    = pending_q;
  assign lane_fatal_o = lfatal_q;
  assign uncorr_o     = w_uncorr;

endmodule
`default_nettype wire

// File: rtl/cv32e40p_ft_err_monitor.sv
`default_nettype none
// ============================================================================
// Module      : cv32e40p_ft_err_monitor
// Description : Error monitor downstream of the TMR majority voters. One lane
//               monitor per voter triplet classifies health and counts
//               corrected events; this level keeps the sticky fatal flag,
//               picks the lowest-index pending lane and runs the one-at-a-time
//               req/ack handshake toward the fault-handling logic.
// Ports       : clk     - core clock
//               rst     - synchronous active-high reset
//               mon_if  - slave side of cv32e40p_ft_err_monitor_if
//                         (voter flags, clear, ack in; lane state, counters,
//                          fatal, request out)
// Config      : FT_ERR_COUNTERS_EN - builds the per-lane corrected counters;
//               undefined ties corr_cnt_o to zero.
// Revision    : 1.0 - initial release
// ============================================================================
module cv32e40p_ft_err_monitor
  import cv32e40p_ft_pkg::*;
#(
  parameter int N_IN        = 1,
  parameter int PERM_THRESH = 4,
  parameter int CNT_W       = 16,
  parameter int LANE_W      = (N_IN > 1) ? $clog2(N_IN) : 1
) (
  input  logic                      clk,
  input  logic                      rst,
  cv32e40p_ft_err_monitor_if.slave  mon_if
);

  logic [N_IN-1:0]             w_pending;
  logic [N_IN-1:0]             w_lane_fatal;
  logic [N_IN-1:0]             w_uncorr;
  logic [N_IN-1:0]             w_ack_lane;
  logic [N_IN-1:0][1:0]        w_state;
  logic [N_IN-1:0][CNT_W-1:0]  w_cnt;

  req_state_e        req_state_q, req_state_d;
  logic [LANE_W-1:0] req_lane_q, req_lane_d;
  logic              req_fatal_q, req_fatal_d;
  logic              fatal_q, fatal_d;

  logic [LANE_W-1:0] w_first_lane;
  logic              w_first_fatal;
  logic              w_any_pending;

  for (genvar i = 0; i < N_IN; i++) begin : g_lane
    // Only the lane named by the outstanding request is acknowledged.
    assign w_ack_lane[i] = (req_state_q == REQ) & mon_if.ack_i &
                           (req_lane_q == LANE_W'(i));

    cv32e40p_ft_lane_monitor #(
      .PERM_THRESH (PERM_THRESH),
      .CNT_W       (CNT_W)
    ) u_lane (
      .clk          (clk),
      .rst          (rst),
      .clear_i      (mon_if.clear_i),
      .valid_i      (mon_if.valid_i),
      .corrected_i  (mon_if.err_corrected_i[i]),
      .detected_i   (mon_if.err_detected_i[i]),
      .ack_i        (w_ack_lane[i]),
      .state_o      (w_state[i]),
      .cnt_o        (w_cnt[i]),
      .pending_o    (w_pending[i]),
      .lane_fatal_o (w_lane_fatal[i]),
      .uncorr_o     (w_uncorr[i])
    );
  end

  // Lowest-index pending lane wins; scanning downward lets the last hit stand.
  always_comb begin
    w_first_lane  = '0;
    w_first_fatal = 1'b0;
    for (int i = N_IN - 1; i >= 0; i--) begin
      if (w_pending[i]) begin
        w_first_lane  = LANE_W'(i);
        w_first_fatal = w_lane_fatal[i];
      end
    end
  end

  assign w_any_pending = |w_pending;

  // Request FSM. Returning to IDLE on ack guarantees at least one low cycle
  // of req_o before the next request is raised.
  always_comb begin
    req_state_d = req_state_q;
    req_lane_d  = req_lane_q;
    req_fatal_d = req_fatal_q;
    unique case (req_state_q)
      IDLE: begin
        if (w_any_pending) begin
          req_state_d = REQ;
          req_lane_d  = w_first_lane;
          req_fatal_d = w_first_fatal;
        end
      end
      REQ: begin
        if (mon_if.ack_i) begin
          req_state_d = IDLE;
        end
      end
      default: begin
        req_state_d = IDLE;
      end
    endcase

    fatal_d = fatal_q | (|w_uncorr);

    if (mon_if.clear_i) begin
      req_state_d = IDLE;
      req_lane_d  = '0;
      req_fatal_d = 1'b0;
      fatal_d     = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      req_state_q <= IDLE;
      req_lane_q  <= '0;
      req_fatal_q <= 1'b0;
      fatal_q     <= 1'b0;
    end else begin
      req_state_q <= req_state_d;
      req_lane_q  <= req_lane_d;
      req_fatal_q <= req_fatal_d;
      fatal_q     <= fatal_d;
    end
  end

  assign mon_if.lane_state_o = w_state;
  assign mon_if.corr_cnt_o   = w_cnt;
  assign mon_if.fatal_o      = fatal_q;
  assign mon_if.req_o        = (req_state_q == REQ);
  assign mon_if.req_lane_o   = req_lane_q;
  assign mon_if.req_fatal_o  = req_fatal_q;

endmodule
`default_nettype wire

// File: tb/tb_cv32e40p_ft_err_monitor.sv
`default_nettype none
// ============================================================================
// Module      : tb_cv32e40p_ft_err_monitor
// Description : Self-checking bench for cv32e40p_ft_err_monitor. Directed
//               scenarios followed by randomized traffic, all checked against
//               a behavioural model; requests are checked through a queue of
//               expected (lane, fatal) pairs popped by an independent monitor.
// Config      : FT_ERR_COUNTERS_EN - expected counter values follow the build
// Revision    : 1.0 - initial release
// ============================================================================
module tb_cv32e40p_ft_err_monitor;

  localparam int N    = 2;
  localparam int PT   = 4;
  localparam int CW   = 4;
  localparam int LW   = 1;
  localparam int CMAX = (1 << CW) - 1;
`ifdef FT_ERR_COUNTERS_EN
  localparam bit CNT_EN = 1'b1;
`else
  localparam bit CNT_EN = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  cv32e40p_ft_err_monitor_if #(.N_IN(N), .CNT_W(CW), .LANE_W(LW)) bus ();

  cv32e40p_ft_err_monitor #(
    .N_IN(N), .PERM_THRESH(PT), .CNT_W(CW), .LANE_W(LW)
  ) dut (
    .clk    (clk),
    .rst    (rst),
    .mon_if (bus)
  );

  int n_checks = 0;
  int n_errors = 0;

  task automatic ck(string name, logic [31:0] act, logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // ---------------- behavioural reference model ----------------
  int m_state  [N];   // 0 OK, 1 SUSPECT, 2 PERMANENT
  int m_run    [N];
  int m_cnt    [N];
  bit m_pend   [N];
  bit m_lfatal [N];
  bit m_fatal;
  bit m_req;
  int m_rlane;
  bit m_rfatal;

  int q_lane  [$];
  bit q_fatal [$];

  function automatic void model(bit v, bit [N-1:0] c, bit [N-1:0] d,
                                bit clr, bit ack, bit r);
    int acked = -1;
    if (r || clr) begin
      for (int i = 0; i < N; i++) begin
        m_state[i] = 0; m_run[i] = 0; m_cnt[i] = 0;
        m_pend[i] = 0;  m_lfatal[i] = 0;
      end
      m_fatal = 0; m_req = 0; m_rlane = 0; m_rfatal = 0;
      return;
    end
    // handshake decisions are made on what was pending before this edge
    if (m_req) begin
      if (ack) begin
        m_req = 0;
        acked = m_rlane;
      end
    end else begin
      for (int i = 0; i < N; i++) begin
        if (m_pend[i]) begin
          m_req = 1; m_rlane = i; m_rfatal = m_lfatal[i];
          q_lane.push_back(i);
          q_fatal.push_back(m_lfatal[i]);
          break;
        end
      end
    end
    if (acked >= 0) begin
      m_pend[acked] = 0;
      m_lfatal[acked] = 0;
    end
    if (v) begin
      for (int i = 0; i < N; i++) begin
        if (c[i]) begin
          m_cnt[i] = (m_cnt[i] < CMAX) ? m_cnt[i] + 1 : CMAX;
          if (m_state[i] == 0) begin
            m_state[i] = 1; m_run[i] = 1;
          end else if (m_state[i] == 1) begin
            m_run[i]++;
            if (m_run[i] == PT) begin
              m_state[i] = 2; m_pend[i] = 1;
            end
          end
        end else if (d[i]) begin
          m_pend[i] = 1; m_lfatal[i] = 1; m_fatal = 1;
        end else if (m_state[i] == 1) begin
          m_state[i] = 0; m_run[i] = 0;
        end
      end
    end
  endfunction

  task automatic check_all();
    for (int i = 0; i < N; i++) begin
      ck($sformatf("lane_state[%0d]", i), 32'(bus.lane_state_o[i]), m_state[i]);
      ck($sformatf("corr_cnt[%0d]", i), 32'(bus.corr_cnt_o[i]), CNT_EN ? m_cnt[i] : 0);
    end
    ck("fatal_o", 32'(bus.fatal_o), 32'(m_fatal));
    ck("req_o", 32'(bus.req_o), 32'(m_req));
    if (m_req) begin
      ck("req_lane_o", 32'(bus.req_lane_o), m_rlane);
      ck("req_fatal_o", 32'(bus.req_fatal_o), 32'(m_rfatal));
    end
  endtask

  // Drive one cycle: inputs set after a falling edge, sampled at the next
  // rising edge, outputs checked at the following falling edge.
  task automatic step(bit v, bit [N-1:0] c, bit [N-1:0] d,
                      bit clr, bit ack, bit r);
    rst                 = r;
    bus.valid_i         = v;
    bus.err_corrected_i = c;
    bus.err_detected_i  = d;
    bus.clear_i         = clr;
    bus.ack_i           = ack;
    model(v, c, d, clr, ack, r);
    @(negedge clk);
    check_all();
  endtask

  // ---------------- scoreboard monitor ----------------
  bit sb_prev  = 1'b0;
  int sb_lane  = 0;
  bit sb_fatal = 1'b0;

  initial begin
    forever begin
      @(negedge clk);
      if (bus.req_o === 1'b1 && !sb_prev) begin
        if (q_lane.size() == 0) begin
          n_checks++;
          n_errors++;
          $display("FAIL sb_unexpected_req: got req lane %0d with no expected request",
                   bus.req_lane_o);
        end else begin
          sb_lane  = q_lane.pop_front();
          sb_fatal = q_fatal.pop_front();
          ck("sb_req_lane", 32'(bus.req_lane_o), sb_lane);
          ck("sb_req_fatal", 32'(bus.req_fatal_o), 32'(sb_fatal));
        end
      end else if (bus.req_o === 1'b1) begin
        ck("sb_req_lane_stable", 32'(bus.req_lane_o), sb_lane);
        ck("sb_req_fatal_stable", 32'(bus.req_fatal_o), 32'(sb_fatal));
      end
      sb_prev = (bus.req_o === 1'b1);
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    bit v, clr, ack, r;
    bit [N-1:0] c, d;
    int pc;

    step(0, 2'b00, 2'b00, 0, 0, 1);
    step(0, 2'b00, 2'b00, 0, 0, 1);
    ck("reset_req_o", 32'(bus.req_o), 0);
    ck("reset_fatal_o", 32'(bus.fatal_o), 0);
    ck("reset_lane_state", 32'(bus.lane_state_o), 0);
    ck("reset_req_lane", 32'(bus.req_lane_o), 0);
    step(0, 2'b00, 2'b00, 0, 0, 0);

    // permanent fault on lane 1
    repeat (PT) step(1, 2'b10, 2'b00, 0, 0, 0);
    ck("perm_state", 32'(bus.lane_state_o[1]), 2);
    ck("perm_cnt", 32'(bus.corr_cnt_o[1]), CNT_EN ? 4 : 0);
    step(0, 2'b00, 2'b00, 0, 0, 0);
    ck("perm_req", 32'(bus.req_o), 1);
    ck("perm_req_lane", 32'(bus.req_lane_o), 1);
    ck("perm_req_fatal", 32'(bus.req_fatal_o), 0);
    step(0, 2'b00, 2'b00, 0, 1, 0);
    ck("perm_ack_drop", 32'(bus.req_o), 0);

    // transient fault on lane 0 with valid gaps
    step(1, 2'b01, 2'b00, 0, 0, 0);
    step(0, 2'b00, 2'b00, 0, 0, 0);
    step(1, 2'b01, 2'b00, 0, 0, 0);
    step(0, 2'b00, 2'b00, 0, 0, 0);
    step(1, 2'b01, 2'b00, 0, 0, 0);
    ck("trans_suspect", 32'(bus.lane_state_o[0]), 1);
    step(1, 2'b00, 2'b00, 0, 0, 0);
    ck("trans_ok", 32'(bus.lane_state_o[0]), 0);
    ck("trans_cnt", 32'(bus.corr_cnt_o[0]), CNT_EN ? 3 : 0);
    step(0, 2'b00, 2'b00, 0, 0, 0);
    ck("trans_no_req", 32'(bus.req_o), 0);

    // uncorrectable on lane 0
    step(1, 2'b00, 2'b01, 0, 0, 0);
    ck("uncorr_fatal", 32'(bus.fatal_o), 1);
    step(0, 2'b00, 2'b00, 0, 0, 0);
    ck("uncorr_req_fatal", 32'(bus.req_fatal_o), 1);
    step(0, 2'b00, 2'b00, 0, 1, 0);
    step(0, 2'b00, 2'b00, 0, 0, 0);
    ck("uncorr_fatal_sticky", 32'(bus.fatal_o), 1);

    // two lanes pending together
    step(1, 2'b00, 2'b11, 0, 0, 0);
    step(0, 2'b00, 2'b00, 0, 0, 0);
    ck("two_first_lane", 32'(bus.req_lane_o), 0);
    step(0, 2'b00, 2'b00, 0, 1, 0);
    ck("two_gap", 32'(bus.req_o), 0);
    step(0, 2'b00, 2'b00, 0, 0, 0);
    ck("two_second_lane", 32'(bus.req_lane_o), 1);
    step(0, 2'b00, 2'b00, 0, 1, 0);

    // saturation
    step(0, 2'b00, 2'b00, 1, 0, 0);
    repeat (20) step(1, 2'b01, 2'b00, 0, m_req, 0);
    ck("sat_cnt", 32'(bus.corr_cnt_o[0]), CNT_EN ? CMAX : 0);

    // clear during request, together with ack and a new event
    step(0, 2'b00, 2'b00, 1, 0, 0);
    step(1, 2'b00, 2'b01, 0, 0, 0);
    step(0, 2'b00, 2'b00, 0, 0, 0);
    ck("clr_req_before", 32'(bus.req_o), 1);
    step(1, 2'b11, 2'b10, 1, 1, 0);
    ck("clr_req", 32'(bus.req_o), 0);
    ck("clr_fatal", 32'(bus.fatal_o), 0);
    ck("clr_state", 32'(bus.lane_state_o), 0);
    ck("clr_cnt", 32'(bus.corr_cnt_o), 0);
    ck("clr_req_lane", 32'(bus.req_lane_o), 0);
    ck("clr_req_fatal", 32'(bus.req_fatal_o), 0);

    // randomized traffic
    for (int k = 0; k < 1500; k++) begin
      pc  = ((k / 300) % 2 == 1) ? 80 : 35;
      v   = ($urandom_range(0, 9) < 7);
      for (int j = 0; j < N; j++) begin
        c[j] = ($urandom_range(0, 99) < pc);
        d[j] = ($urandom_range(0, 99) < 10);
      end
      clr = ($urandom_range(0, 199) == 0);
      r   = ($urandom_range(0, 299) == 0);
      ack = m_req ? ($urandom_range(0, 2) != 0) : ($urandom_range(0, 9) == 0);
      step(v, c, d, clr, ack, r);
    end

    // drain outstanding requests
    for (int k = 0; k < 12; k++) step(0, 2'b00, 2'b00, 0, m_req, 0);
    ck("sb_queue_empty", q_lane.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire
